min_sort_ctrl: RTL and testbench

Sequential sorter built around a single shared 3-bit compare/select unit, which computes min/max of two operands. The block accepts N unsigned values over a valid/ready input stream and sorts them in place with a fixed-schedule bubble sort. It issues one compare-and-swap per clock and then streams the values out in ascending order. It is the scheduling/control layer that time-multiplexes one comparator across all entry pairs.

---
 rtl/min_sort_ctrl_if.sv | 25 ++
 rtl/min_sort_ctrl.sv | 114 +++++++++++
 tb/tb_min_sort_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/min_sort_ctrl_if.sv
// Stream and status bundle for min_sort_ctrl: valid/ready input, valid/ready
// sorted output, plus busy/done/swap_cnt status.
interface min_sort_ctrl_if #(
  parameter int W = 3
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic [7:0]   swap_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, swap_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, swap_cnt
  );
endinterface

// File: rtl/min_sort_ctrl.sv
// Batch sorter: loads N words, bubble-sorts them in place with one shared
// min/max unit (one compare per clock, fixed schedule), streams them out ascending.
module min_sort_ctrl #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  min_sort_ctrl_if.slave io_bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [CW-1:0] LAST_W = CW'(N - 1);
  localparam logic [CW-1:0] LAST_I = CW'(N - 2);

  logic [1:0]    r_state;
  logic [W-1:0]  r_buf [N];
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_p;
  logic [CW-1:0] r_i;
  logic [7:0]    r_swap_cnt;
  logic          r_done;

  logic [CW-1:0] w_i1;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_min;
  logic [W-1:0]  w_max;
  logic          w_gt;

  assign w_i1 = r_i + CW'(1);

  // The single compare/select unit, time-shared across all adjacent pairs.
  always_comb begin
    w_a   = r_buf[r_i];
    w_b   = r_buf[w_i1];
    w_gt  = (w_a > w_b);
    w_min = w_gt ? w_b : w_a;
    w_max = w_gt ? w_a : w_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOAD;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_p        <= '0;
      r_i        <= '0;
      r_swap_cnt <= '0;
      r_done     <= 1'b0;
      for (int k = 0; k < N; k++) r_buf[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (io_bus.in_valid) begin
            r_buf[r_wr_cnt] <= io_bus.in_data;
            if (r_wr_cnt == LAST_W) begin
              r_wr_cnt   <= '0;
              r_p        <= '0;
              r_i        <= '0;
              r_swap_cnt <= '0;
              r_state    <= S_SORT;
            end else begin
              r_wr_cnt <= r_wr_cnt + CW'(1);
            end
          end
        end
        S_SORT: begin
          // Strict greater-than: equal neighbours stay put, keeping the sort stable.
          if (w_gt) begin
            r_buf[r_i]  <= w_min;
            r_buf[w_i1] <= w_max;
            r_swap_cnt  <= r_swap_cnt + 8'd1;
          end
          if (r_i == LAST_I) begin
            r_i <= '0;
            r_p <= r_p + CW'(1);
            if (r_p == LAST_I) begin
              r_rd_cnt <= '0;
              r_state  <= S_OUT;
            end
          end else begin
            r_i <= w_i1;
          end
        end
        S_OUT: begin
          if (io_bus.out_ready) begin
            if (r_rd_cnt == LAST_W) begin
              r_rd_cnt <= '0;
              r_done   <= 1'b1;
              r_state  <= S_LOAD;
            end else begin
              r_rd_cnt <= r_rd_cnt + CW'(1);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign io_bus.in_ready  = (r_state == S_LOAD);
  assign io_bus.busy      = (r_state == S_SORT) || (r_state == S_OUT);
  assign io_bus.out_valid = (r_state == S_OUT);
  assign io_bus.out_data  = (r_state == S_OUT) ? r_buf[r_rd_cnt] : '0;
  assign io_bus.done      = r_done;
  assign io_bus.swap_cnt  = r_swap_cnt;
endmodule

// File: tb/tb_min_sort_ctrl.sv
// Directed and randomized bench for min_sort_ctrl; expected order and swap
// count come from a queue sort and an inversion count of each batch.
module tb_min_sort_ctrl;
  localparam int N = 4;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  min_sort_ctrl_if #(.W(W)) bus ();

  min_sort_ctrl #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // gap: 0 none, 1 one idle cycle before every word, 2 random idle cycles
  task automatic load(input int v[N], input int gap);
    for (int k = 0; k < N; k++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom_range(0, 7));
        @(negedge clk);
      end
      chk("load_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(v[k]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts SORT cycles while offering junk input that must be ignored.
  task automatic wait_sort();
    int cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 50) begin
      chk("sort_in_ready", bus.in_ready, 0);
      chk("sort_busy", bus.busy, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom_range(0, 7));
      cnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("sort_cycles", cnt, (N - 1) * (N - 1));
  endtask

  // mode: 0 always ready, 1 ready low for 3 cycles on the first word, 2 random
  task automatic drain(input int exp_q[$], input int mode, input int exp_sw);
    int   j   = 0;
    int   cyc = 0;
    logic rdy;
    while (j < N && cyc < 200) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc >= 3);
      else                rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, exp_q[j]);
      chk("out_done_low", bus.done, 0);
      chk("out_busy", bus.busy, 1);
      @(negedge clk);
      cyc++;
      if (rdy) j++;
    end
    bus.out_ready = 1'b1;
    chk("drain_bound", (cyc < 200), 1);
    chk("done_pulse", bus.done, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_out_data", bus.out_data, 0);
    chk("swap_cnt", bus.swap_cnt, exp_sw);
    @(negedge clk);
    chk("done_cleared", bus.done, 0);
    chk("swap_cnt_hold", bus.swap_cnt, exp_sw);
  endtask

  task automatic batch(input int v[N], input int gap, input int mode);
    int q[$];
    int inv = 0;
    for (int a = 0; a < N; a++) begin
      q.push_back(v[a]);
      for (int b = a + 1; b < N; b++) if (v[a] > v[b]) inv++;
    end
    q.sort();
    load(v, gap);
    wait_sort();
    drain(q, mode, inv);
  endtask

  initial begin
    int v[N];
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_swap_cnt", bus.swap_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    v = '{5, 3, 7, 1}; batch(v, 0, 0);
    v = '{0, 1, 2, 3}; batch(v, 0, 0);
    v = '{7, 6, 5, 4}; batch(v, 0, 0);
    v = '{2, 2, 0, 2}; batch(v, 1, 0);
    v = '{5, 3, 7, 1}; batch(v, 0, 1);

    // Asynchronous reset four cycles into SORT.
    v = '{7, 6, 5, 4};
    load(v, 0);
    repeat (4) @(negedge clk);
    chk("pre_rst_swaps", bus.swap_cnt, 4);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_swap_cnt", bus.swap_cnt, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = '{6, 0, 3, 1}; batch(v, 0, 0);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 7));
      batch(v, 2, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
